// File: rtl/uart_word_tx_if.sv
// Word handshake bundle between a word producer and uart_word_tx.
// The producer drives data/valid; the transmitter answers with ready.
interface uart_word_tx_if;
  logic [31:0] word_data;
  logic        word_valid;
  logic        word_ready;

  modport master (
    output word_data,
    output word_valid,
    input  word_ready
  );

  modport slave (
    input  word_data,
    input  word_valid,
    output word_ready
  );
endinterface

// File: rtl/uart_word_tx.sv
// uart_word_tx: accepts one 32-bit word per valid/ready handshake and sends
// it as four 8N1 UART bytes, least-significant byte first. Each bit lasts
// WAIT clocks and uart_tx comes straight from a flop.
module uart_word_tx #(
  parameter int WAIT = 868
) (
  input  logic           clk,
  input  logic           reset,
  uart_word_tx_if.slave  s_word,
  output logic           uart_tx,
  output logic           busy
);

  localparam int            CW   = $clog2(WAIT);
  localparam logic [CW-1:0] LAST = CW'(WAIT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_nxt;
  logic [2:0]    r_bit;
  logic [2:0]    w_bit_nxt;
  logic [1:0]    r_byte;
  logic [1:0]    w_byte_nxt;
  logic [31:0]   r_shift;
  logic [31:0]   w_shift_nxt;
  logic          r_tx;
  logic          w_tx_nxt;
  logic          w_tick;

  // Last clock of the current bit period.
  assign w_tick = (r_cnt == LAST);

  assign s_word.word_ready = (r_state == S_IDLE);
  assign busy              = (r_state != S_IDLE);
  assign uart_tx           = r_tx;

  // Control state, counters and the line flop; reset drops any word in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_bit   <= '0;
      r_byte  <= '0;
      r_tx    <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_bit   <= w_bit_nxt;
      r_byte  <= w_byte_nxt;
      r_tx    <= w_tx_nxt;
    end
  end

  // Word shift register; bit 0 is always the next data bit to go out.
  always_ff @(posedge clk) begin
    r_shift <= w_shift_nxt;
  end

  // Next-state, counter and line-value decode. The line value is computed
  // from the next state so the flop presents each bit right at its boundary.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_bit_nxt   = r_bit;
    w_byte_nxt  = r_byte;
    w_shift_nxt = r_shift;
    w_tx_nxt    = 1'b1;

    case (r_state)
      S_IDLE: begin
        if (s_word.word_valid) begin
          w_state_nxt = S_START;
          w_cnt_nxt   = '0;
          w_byte_nxt  = '0;
          w_shift_nxt = s_word.word_data;
        end
      end
      S_START: begin
        if (w_tick) begin
          w_state_nxt = S_DATA;
          w_cnt_nxt   = '0;
          w_bit_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end
      S_DATA: begin
        if (w_tick) begin
          w_cnt_nxt   = '0;
          w_shift_nxt = {1'b0, r_shift[31:1]};
          if (r_bit == 3'd7) begin
            w_state_nxt = S_STOP;
          end else begin
            w_bit_nxt = r_bit + 3'd1;
          end
        end else begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end
      S_STOP: begin
        if (w_tick) begin
          w_cnt_nxt = '0;
          if (r_byte == 2'd3) begin
            w_state_nxt = S_IDLE;
          end else begin
            w_byte_nxt  = r_byte + 2'd1;
            w_state_nxt = S_START;
          end
        end else begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase

    case (w_state_nxt)
      S_START: w_tx_nxt = 1'b0;
      S_DATA:  w_tx_nxt = w_shift_nxt[0];
      default: w_tx_nxt = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_uart_word_tx.sv
// Bench for uart_word_tx: two instances (WAIT=4 and WAIT=2) driven with
// directed and random words; the line is compared every clock against a
// frame model built from the 8N1 byte rules.
module tb_uart_word_tx;

  localparam int NO_ABORT = 1 << 30;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n = 1'b1;
  logic [1:0]  r_valid = 2'b00;
  logic [31:0] r_data0 = '0;
  logic [31:0] r_data1 = '0;
  logic        tx4, busy4, tx2, busy2;

  int n_vec = 0;
  int n_err = 0;

  uart_word_tx_if u_if4();
  uart_word_tx_if u_if2();

  assign u_if4.word_valid = r_valid[0];
  assign u_if4.word_data  = r_data0;
  assign u_if2.word_valid = r_valid[1];
  assign u_if2.word_data  = r_data1;

  uart_word_tx #(.WAIT(4)) u_dut4 (
    .clk     (clk),
    .reset   (rst_n),
    .s_word  (u_if4),
    .uart_tx (tx4),
    .busy    (busy4)
  );

  uart_word_tx #(.WAIT(2)) u_dut2 (
    .clk     (clk),
    .reset   (rst_n),
    .s_word  (u_if2),
    .uart_tx (tx2),
    .busy    (busy2)
  );

  function automatic int wait_of(int d);
    return (d == 0) ? 4 : 2;
  endfunction

  function automatic logic get_tx(int d);
    return (d == 0) ? tx4 : tx2;
  endfunction

  function automatic logic get_busy(int d);
    return (d == 0) ? busy4 : busy2;
  endfunction

  function automatic logic get_ready(int d);
    return (d == 0) ? u_if4.word_ready : u_if2.word_ready;
  endfunction

  // Expected line level j clocks after the handshake edge: 40 bit slots of
  // W clocks; slot 0 of every 10 is the start bit, slot 9 the stop bit.
  function automatic logic exp_line(logic [31:0] w, int W, int j);
    int slot;
    int byt;
    int pos;
    logic [7:0] b;
    slot = j / W;
    byt  = slot / 10;
    pos  = slot % 10;
    b    = w[byt*8 +: 8];
    if (pos == 0) return 1'b0;
    if (pos == 9) return 1'b1;
    return b[pos-1];
  endfunction

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      if (n_err <= 40)
        $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic drive(int d, logic v, logic [31:0] dat);
    if (d == 0) begin
      r_valid[0] = v;
      r_data0    = dat;
    end else begin
      r_valid[1] = v;
      r_data1    = dat;
    end
  endtask

  task automatic check_idle(int d, string tag);
    check({tag, "_tx"},    {31'd0, get_tx(d)},    32'd1);
    check({tag, "_rdy"},   {31'd0, get_ready(d)}, 32'd1);
    check({tag, "_busy"},  {31'd0, get_busy(d)},  32'd0);
  endtask

  // Called at a negedge with the DUT idle. Presents w, lets the next rising
  // edge take it, then either drops valid or keeps valid high with 'after'
  // on the data lines. Checks every clock of the word; returns early after
  // stop_j clocks when a reset is to be injected.
  task automatic send_word(int d, logic [31:0] w, bit hold,
                           logic [31:0] after, int stop_j);
    int W;
    W = wait_of(d);
    check("rdy_pre", {31'd0, get_ready(d)}, 32'd1);
    drive(d, 1'b1, w);
    @(posedge clk);
    @(negedge clk);
    drive(d, hold, after);
    for (int j = 0; j < 40 * W; j++) begin
      if (j == stop_j) return;
      check($sformatf("tx_w%0d_j%0d", W, j), {31'd0, get_tx(d)},
            {31'd0, exp_line(w, W, j)});
      check("busy_run", {31'd0, get_busy(d)},  32'd1);
      check("rdy_run",  {31'd0, get_ready(d)}, 32'd0);
      @(negedge clk);
    end
    check_idle(d, "end");
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] cur;
    logic [31:0] nxt;
    bit          hold;
    int          d;

    // Asynchronous reset: outputs must settle with no clock edge.
    #1 rst_n = 1'b0;
    #1;
    check_idle(0, "rst4");
    check_idle(1, "rst2");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Single word, WAIT=4.
    send_word(0, 32'h54311101, 1'b0, 32'h0, NO_ABORT);

    // Back-to-back with valid held: one idle clock between words.
    send_word(0, 32'h12345678, 1'b1, 32'h54322201, NO_ABORT);
    send_word(0, 32'h54322201, 1'b0, 32'h0, NO_ABORT);

    // Data changes after acceptance must not reach the line.
    send_word(0, 32'hFFFFFFFF, 1'b1, 32'h0, NO_ABORT);
    drive(0, 1'b0, 32'h0);
    @(negedge clk);

    // Pattern extremes at WAIT=2.
    send_word(1, 32'h00000000, 1'b0, 32'h0, NO_ABORT);
    send_word(1, 32'hAAAA5555, 1'b0, 32'h0, NO_ABORT);

    // Reset in the middle of data bit 3 of byte 1.
    send_word(0, 32'h54311101, 1'b0, 32'h0, 58);
    #2 rst_n = 1'b0;
    #1;
    check_idle(0, "midrst");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_idle(0, "postrst");
    send_word(0, 32'h000000A5, 1'b0, 32'h0, NO_ABORT);

    // Random words on random instances; held valid forms back-to-back pairs.
    nxt  = $urandom;
    hold = 1'b0;
    d    = 0;
    for (int i = 0; i < 16; i++) begin
      cur = nxt;
      nxt = $urandom;
      if (!hold) d = $urandom_range(0, 1);
      hold = (i < 15) ? bit'($urandom_range(0, 1)) : 1'b0;
      send_word(d, cur, hold, nxt, NO_ABORT);
      if (!hold) begin
        int gap;
        gap = $urandom_range(0, 3);
        for (int g = 0; g < gap; g++) begin
          @(negedge clk);
          check_idle(d, "gap");
        end
      end
    end
    drive(0, 1'b0, 32'h0);
    drive(1, 1'b0, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
